// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM state encoding, word size and the
// per-slot base address helper.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } apb_slv_state_e;

   localparam int unsigned WORD_BYTES = 4;

   // Byte base address of slave slot 'id' when each slot holds 'depth' words.
   function automatic logic [63:0] slave_base(input int unsigned id,
                                              input int unsigned depth = 64);
      return 64'(id) * 64'(depth) * 64'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/apb_slave_ram.sv
// Word-wide register-file memory with a synchronous write port and a
// registered read port. The array 'mem' is the backdoor probe target.
module apb_slave_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned IDX_W      = 6
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: one word per cycle when enabled; contents are never reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port: captures the addressed word only when a read is launched.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer for one slave slot: address decode and error check, a fixed
// wait-state stretch, and word read/write access to a local memory.
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in
// IDLE; pready is a registered one-cycle strobe in RESP, and the write commits
// on the edge that ends RESP only while psel and penable are still high.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int unsigned SLAVE_ID    = 0,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 64,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output apb_slv_state_e        fsm_state
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [63:0] BASE64  = slave_base(SLAVE_ID, MEM_DEPTH);
   localparam logic [63:0] LIMIT64 = BASE64 + 64'(MEM_DEPTH) * 64'(WORD_BYTES);
   // One extra bit so the upper limit of the last slot does not wrap.
   localparam logic [ADDR_WIDTH:0] BASE  = BASE64[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] LIMIT = LIMIT64[ADDR_WIDTH:0];
   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   apb_slv_state_e        state, next_state;
   logic [3:0]            cnt, cnt_next;
   logic [ADDR_WIDTH:0]   addr_ext;
   logic                  err_now, err_q, err_sel;
   logic [IDX_W-1:0]      idx_now, idx_q, idx_sel;
   logic                  wr_q, wr_sel;
   logic [DATA_WIDTH-1:0] wdata_q, ram_rdata;
   logic                  setup, rd_en, we;
   logic                  pready_q, pslverr_q;

   // Decode of the live bus address, used when a setup phase is accepted.
   always_comb begin
      addr_ext = {1'b0, paddr};
      err_now  = (paddr[1:0] != 2'b00) || (addr_ext < BASE) || (addr_ext >= LIMIT);
      idx_now  = IDX_W'((addr_ext - BASE) >> 2);
   end

   // Next-state and counter logic; aborts win over completion in WAIT and RESP.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      setup      = 1'b0;
      unique case (state)
         IDLE: begin
            if (psel && !penable) begin
               setup = 1'b1;
               if (WAIT_STATES == 0) begin
                  next_state = RESP;
               end else begin
                  next_state = WAIT;
                  cnt_next   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (!psel || !penable) next_state = IDLE;
            else if (cnt == 4'd0)  next_state = RESP;
            else                   cnt_next   = cnt - 4'd1;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // With zero wait states RESP is entered straight from IDLE, so the live
   // decode is used; otherwise the values latched at setup are used.
   always_comb begin
      err_sel = (state == IDLE) ? err_now : err_q;
      idx_sel = (state == IDLE) ? idx_now : idx_q;
      wr_sel  = (state == IDLE) ? pwrite  : wr_q;
      rd_en   = (next_state == RESP) && !wr_sel && !err_sel;
      we      = (state == RESP) && psel && penable && wr_q && !err_q && presetn;
   end

   // State register and registered response outputs.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= cnt_next;
         pready_q  <= (next_state == RESP);
         pslverr_q <= (next_state == RESP) && err_sel;
      end
   end

   // Transfer attributes captured in the setup phase.
   always_ff @(posedge pclk) begin
      if (setup) begin
         err_q   <= err_now;
         idx_q   <= idx_now;
         wr_q    <= pwrite;
         wdata_q <= pwdata;
      end
   end

   apb_slave_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk   (pclk),
      .we    (we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .re    (rd_en),
      .raddr (idx_sel),
      .rdata (ram_rdata)
   );

   // Read data is only driven during a successful read response.
   assign prdata    = (pready_q && !pslverr_q && !wr_q) ? ram_rdata : '0;
   assign pready    = pready_q;
   assign pslverr   = pslverr_q;
   assign fsm_state = state;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (slot 2 / 1 wait, slot 0 / 0 wait,
// slot 0 / 3 waits) share the bus signals except psel.
module tb_apb_slave_mem;
   import apb_pkg::*;

   // ---------------- clock / reset ----------------
   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic        presetn, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        psel_a, psel_b, psel_c;
   logic [31:0] prdata_a, prdata_b, prdata_c;
   logic        pready_a, pready_b, pready_c;
   logic        pslverr_a, pslverr_b, pslverr_c;
   apb_slv_state_e st_a, st_b, st_c;

   apb_slave_mem #(.SLAVE_ID(2), .WAIT_STATES(1)) u_a (
      .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
      .pready(pready_a), .pslverr(pslverr_a), .fsm_state(st_a));
   apb_slave_mem #(.SLAVE_ID(0), .WAIT_STATES(0)) u_b (
      .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
      .pready(pready_b), .pslverr(pslverr_b), .fsm_state(st_b));
   apb_slave_mem #(.SLAVE_ID(0), .WAIT_STATES(3)) u_c (
      .pclk(pclk), .presetn(presetn), .psel(psel_c), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_c),
      .pready(pready_c), .pslverr(pslverr_c), .fsm_state(st_c));

   int checks   = 0;
   int failures = 0;
   int dbl      = 0;
   logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

   // pready must never stay high two cycles in a row on any instance.
   always @(negedge pclk) begin
      if ((pready_a && prev_a) || (pready_b && prev_b) || (pready_c && prev_c)) dbl++;
      prev_a = pready_a;
      prev_b = pready_b;
      prev_c = pready_c;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic get_ready(input int d);
      case (d)
         0: return pready_a;
         1: return pready_b;
         default: return pready_c;
      endcase
   endfunction

   function automatic logic get_err(input int d);
      case (d)
         0: return pslverr_a;
         1: return pslverr_b;
         default: return pslverr_c;
      endcase
   endfunction

   function automatic logic [31:0] get_rdata(input int d);
      case (d)
         0: return prdata_a;
         1: return prdata_b;
         default: return prdata_c;
      endcase
   endfunction

   task automatic set_psel(input int d, input logic v);
      psel_a = (d == 0) ? v : 1'b0;
      psel_b = (d == 1) ? v : 1'b0;
      psel_c = (d == 2) ? v : 1'b0;
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; setup occupies the following cycle.
   task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat, output logic seen,
                       output logic quiet);
      rd = '0; er = 1'b0; lat = -1; seen = 1'b0; quiet = 1'b1;
      set_psel(d, 1'b1);
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      @(negedge pclk);
      if (get_ready(d) || get_err(d) || get_rdata(d) != 0) quiet = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk);
         if (get_ready(d)) begin
            seen = 1'b1; lat = i; rd = get_rdata(d); er = get_err(d);
            break;
         end else if (get_err(d) || get_rdata(d) != 0) quiet = 1'b0;
      end
      @(posedge pclk); #1;
      set_psel(d, 1'b0);
      penable = 1'b0;
   endtask

   typedef struct {
      int          d;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic        chk_rd;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic [31:0] rd;
      logic er, seen, quiet;
      int lat, cnt;

      vecs[0]  = '{0, 1'b1, 32'h208, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1};
      vecs[1]  = '{0, 1'b0, 32'h208, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1};
      vecs[2]  = '{0, 1'b1, 32'h200, 32'h0BADCAFE, 1'b0, 1'b0, 32'h0,        1};
      vecs[3]  = '{0, 1'b1, 32'h202, 32'h11111111, 1'b1, 1'b0, 32'h0,        1};
      vecs[4]  = '{0, 1'b0, 32'h200, 32'h0,        1'b0, 1'b1, 32'h0BADCAFE, 1};
      vecs[5]  = '{0, 1'b0, 32'h300, 32'h0,        1'b1, 1'b1, 32'h0,        1};
      vecs[6]  = '{0, 1'b1, 32'h2FC, 32'h5A5AA5A5, 1'b0, 1'b0, 32'h0,        1};
      vecs[7]  = '{0, 1'b0, 32'h2FC, 32'h0,        1'b0, 1'b1, 32'h5A5AA5A5, 1};
      vecs[8]  = '{0, 1'b0, 32'h1FC, 32'h0,        1'b1, 1'b1, 32'h0,        1};
      vecs[9]  = '{0, 1'b1, 32'h1FC, 32'h77777777, 1'b1, 1'b0, 32'h0,        1};
      vecs[10] = '{1, 1'b1, 32'h000, 32'h01234567, 1'b0, 1'b0, 32'h0,        0};
      vecs[11] = '{1, 1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 32'h01234567, 0};
      vecs[12] = '{1, 1'b1, 32'h004, 32'h89ABCDEF, 1'b0, 1'b0, 32'h0,        0};
      vecs[13] = '{1, 1'b0, 32'h004, 32'h0,        1'b0, 1'b1, 32'h89ABCDEF, 0};
      vecs[14] = '{2, 1'b1, 32'h010, 32'h3C3C3C3C, 1'b0, 1'b0, 32'h0,        3};
      vecs[15] = '{2, 1'b0, 32'h010, 32'h0,        1'b0, 1'b1, 32'h3C3C3C3C, 3};
      vecs[16] = '{2, 1'b0, 32'h012, 32'h0,        1'b1, 1'b1, 32'h0,        3};

      // ---------------- reset ----------------
      presetn = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      set_psel(0, 1'b0);
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      check("rst_pready_a",  32'(pready_a),  32'h0);
      check("rst_pslverr_a", 32'(pslverr_a), 32'h0);
      check("rst_prdata_a",  prdata_a,       32'h0);
      check("rst_state_a",   32'(st_a),      32'(IDLE));
      check("rst_state_c",   32'(st_c),      32'(IDLE));
      @(posedge pclk); #1;
      presetn = 1'b1;

      // ---------------- table-driven transfers (back to back) ----------------
      for (int i = 0; i < 17; i++) begin
         xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat, seen, quiet);
         check($sformatf("v%0d_seen", i), 32'(seen), 32'h1);
         check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_quiet", i), 32'(quiet), 32'h1);
         if (vecs[i].chk_rd) check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
      end

      // ---------------- backdoor checks ----------------
      check("bd_a_mem2",  u_a.u_ram.mem[2],  32'hDEADBEEF);
      check("bd_a_mem0",  u_a.u_ram.mem[0],  32'h0BADCAFE);
      check("bd_a_mem63", u_a.u_ram.mem[63], 32'h5A5AA5A5);
      check("bd_b_mem1",  u_b.u_ram.mem[1],  32'h89ABCDEF);
      check("bd_c_mem4",  u_c.u_ram.mem[4],  32'h3C3C3C3C);

      // ---------------- abort: psel dropped in WAIT ----------------
      xfer(0, 1'b1, 32'h20C, 32'hAAAA5555, rd, er, lat, seen, quiet);
      check("pre_abort_seen", 32'(seen), 32'h1);
      set_psel(0, 1'b1); penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h20C; pwdata = 32'h12345678;
      @(posedge pclk); #1;
      penable = 1'b1;
      set_psel(0, 1'b0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         if (pready_a) cnt++;
      end
      penable = 1'b0;
      check("abort_no_pready", 32'(cnt), 32'h0);
      check("abort_state", 32'(st_a), 32'(IDLE));
      check("abort_mem3", u_a.u_ram.mem[3], 32'hAAAA5555);

      // ---------------- reset asserted during RESP ----------------
      @(posedge pclk); #1;
      set_psel(0, 1'b1); penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h20C; pwdata = 32'hCAFEF00D;
      @(posedge pclk); #1;
      penable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk);
         if (pready_a) begin seen = 1'b1; break; end
      end
      check("rst_resp_seen", 32'(seen), 32'h1);
      presetn = 1'b0;
      @(negedge pclk);
      check("rst_resp_pready", 32'(pready_a), 32'h0);
      check("rst_resp_prdata", prdata_a, 32'h0);
      presetn = 1'b1;
      set_psel(0, 1'b0); penable = 1'b0;
      @(posedge pclk); #1;
      check("rst_resp_mem3", u_a.u_ram.mem[3], 32'hAAAA5555);
      xfer(0, 1'b0, 32'h20C, 32'h0, rd, er, lat, seen, quiet);
      check("post_rst_read", rd, 32'hAAAA5555);
      check("post_rst_lat", 32'(lat), 32'h1);

      check("no_double_pready", 32'(dbl), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer memory for one slave slot on the shared APB bus: decodes this slot's select, inserts a fixed number of wait states, and services word reads and writes to a local register-file memory. It sits directly downstream of the APB bus interface. One instance is built per slave index, and the interconnect muxes `pready`/`prdata`/`pslverr` by `psel`. Its memory array is the backdoor target for frontdoor-write/backdoor-read checks.

## Interface
- `SLAVE_ID`, 0: slave index; sets the base address `SLAVE_ID*MEM_DEPTH*4`.
- `ADDR_WIDTH`, 32: `paddr` width (`ADDR_WIDTH` macro).
- `DATA_WIDTH`, 32: data width (`DATA_WIDTH` macro).
- `MEM_DEPTH`, 64: words per slave (256 bytes).
- `WAIT_STATES`, 1: cycles `pready` is held low in the access phase (0–15).
- `pclk`  in  1  clock; all logic on the rising edge.
- `presetn`  in  1  reset; one clock; synchronous, active-low.
- `psel`  in  1  this slot's select (`psel[SLAVE_ID]` of the bus vector).
- `penable`  in  1  access-phase strobe.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `prdata`  out  DATA_WIDTH  read data; valid only while `pready`=1.
- `pready`  out  1  transfer-complete strobe.
- `pslverr`  out  1  error response; valid only while `pready`=1.

## Operation
- State is sampled only when `presetn`=0 at a `pclk` edge: FSM→IDLE, `pready`=0, `pslverr`=0, `prdata`=0, counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** on `psel`=1 and `penable`=0 (setup), latch `paddr`/`pwrite`/`pwdata` and compute the error flag.
  - If `WAIT_STATES`=0 → RESP.
  - Otherwise → WAIT with counter=`WAIT_STATES`-1.
- **WAIT:** if counter=0 → RESP, else decrement the counter.
- **RESP:** `pready`=1 for exactly one cycle. The edge that ends RESP with `psel`=`penable`=1 commits the write (if no error); the FSM then returns to IDLE.
- **Abort:** in WAIT or RESP, `psel`=0 or `penable`=0 → IDLE immediately; no write, no response.
- **Error** is flagged when any of these hold:
  - `paddr[1:0]`≠0;
  - `paddr` < base;
  - `paddr` ≥ base+4*`MEM_DEPTH`.
- **On error:**
  - `pslverr`=1 in RESP;
  - writes are dropped;
  - `prdata`=0.
- **Index:** word index = (`paddr`-base)>>2, width `$clog2(MEM_DEPTH)`.
- **Read:** `prdata` is loaded from `mem[idx]` on the edge entering RESP. It returns to 0 when leaving RESP.
- **Back-to-back transfers:** a setup phase in the cycle after RESP is accepted from IDLE, with no idle gap required.

## Timing
- Setup in cycle T0 and access from T1 → `pready`=1 in cycle T1+`WAIT_STATES`.
- Transfer length is 2+`WAIT_STATES` cycles.
- A write is visible to a read whose setup starts in the cycle after its RESP.
- `pready`, `pslverr` and `prdata` are registered; there is no combinational path from inputs to outputs.
- Outputs are 0 in every cycle outside RESP.
- Reset asserted mid-transfer takes effect on that edge: no commit, outputs are 0 next cycle.

## Structure
- The shared package `apb_pkg` holds the FSM enum `apb_slv_state_e` {IDLE, WAIT, RESP}, `WORD_BYTES`=4, and the function `slave_base(id)`.
- Memory is a separate sub-module `apb_slave_ram`: a synchronous write and registered read array named `mem`, which is the hierarchical probe target.
- The FSM, decode and error logic stay in `apb_slave_mem`.

## Test plan
- **Plain write then read:** `SLAVE_ID`=2, `WAIT_STATES`=1. Write 0xDEADBEEF to 0x208, then read 0x208 → `pready` at T2, `prdata`=0xDEADBEEF, `pslverr`=0; backdoor `mem[2]`=0xDEADBEEF.
- **Zero wait states:** `WAIT_STATES`=0, read 0x000 → `pready` in T1, transfer is 2 cycles; back-to-back write+read with no gap both complete.
- **Errors:**
  - misaligned write to 0x202 → `pslverr`=1, memory unchanged;
  - read to 0x300 with `SLAVE_ID`=2 → `pslverr`=1, `prdata`=0.
- **Wait stretch:** `WAIT_STATES`=3 → `pready` low for 3 access cycles, high in the 4th; `pready` is never high for 2 consecutive cycles.
- **Abort and reset:**
  - `psel` dropped in WAIT of a write of 0x12345678 → no `pready`, mem unchanged;
  - `presetn`=0 during RESP → `pready`=0 next cycle, no commit; mem keeps prior data.
- **Boundaries:** write/read of the last word 0x2FC (idx 63) → `pslverr`=0 and data is correct; 0x1FC with `SLAVE_ID`=2 → `pslverr`=1.
